// File: rtl/psola_output_streamer.sv
`default_nettype none
// ============================================================================
// Module   : psola_output_streamer
// Purpose  : Takes the burst of 32-bit PSOLA samples coming out of the BRAM
//            wrapper, scales (arithmetic shift) and saturates each one to
//            16-bit audio, buffers it in a FIFO, and replays one sample per
//            audio-rate tick. A PRIME/PLAY policy keeps the stream continuous
//            and recovers from underflow by re-priming.
// Ports    : clk_in, rst_n_in            clock, async active-low reset
//            val_in, addr_in, valid_in   incoming sample, window index, strobe
//            sample_tick_in              audio-rate request strobe
//            clear_flags_in              clears the sticky error flags
//            sample_out/sample_valid_out replayed sample, one pulse per tick
//            fill_out, playing_out       FIFO occupancy, PLAY-state indicator
//            overflow_out, underflow_out, addr_err_out  sticky error flags
// Revision : 1.0  initial release
// ============================================================================
module psola_output_streamer #(
  parameter int MAX_EXTENDED = 2200,
  parameter int FIFO_DEPTH   = 4096,
  parameter int SHIFT        = 8,
  parameter int PRIME_LEVEL  = 1024,
  localparam int AW = $clog2(MAX_EXTENDED),
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int FW = PW + 1
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic [31:0]   val_in,
  input  logic [AW-1:0] addr_in,
  input  logic          valid_in,
  input  logic          sample_tick_in,
  input  logic          clear_flags_in,
  output logic [15:0]   sample_out,
  output logic          sample_valid_out,
  output logic [FW-1:0] fill_out,
  output logic          playing_out,
  output logic          overflow_out,
  output logic          underflow_out,
  output logic          addr_err_out
);

  localparam logic [0:0]        C_ST_PRIME  = 1'b0;
  localparam logic [0:0]        C_ST_PLAY   = 1'b1;
  localparam logic [FW-1:0]     C_FULL      = FW'(FIFO_DEPTH);
  localparam logic [FW-1:0]     C_PRIME_LVL = FW'(PRIME_LEVEL);
  localparam logic signed [31:0] C_SAT_MAX  = 32'sd32767;
  localparam logic signed [31:0] C_SAT_MIN  = -32'sd32768;

  // Registered state
  logic [0:0]    state_q,     state_d;
  logic [FW-1:0] fill_q,      fill_d;
  logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [AW-1:0] exp_addr_q,  exp_addr_d;
  logic          overflow_q,  overflow_d;
  logic          underflow_q, underflow_d;
  logic          addr_err_q,  addr_err_d;
  logic          tick1_q,     tick1_d;
  logic          zero1_q,     zero1_d;
  logic          valid_q,     valid_d;
  logic [15:0]   sample_q,    sample_d;

  // FIFO storage (no reset, 1-cycle read latency)
  logic [15:0]   ram_q [FIFO_DEPTH];
  logic [15:0]   rd_data_q;

  // Combinational control
  logic signed [31:0] shifted;
  logic [15:0]        sat_val;
  logic               pop;
  logic               emit_zero;
  logic               underflow_set;
  logic               push_ok;
  logic               overflow_set;
  logic               addr_err_set;

  // --------------------------------------------------------------------------
  // Push path: scale then clamp to the 16-bit signed range
  // --------------------------------------------------------------------------
  always_comb begin
    shifted = $signed(val_in) >>> SHIFT;
    if (shifted > C_SAT_MAX) begin
      sat_val = 16'h7FFF;
    end else if (shifted < C_SAT_MIN) begin
      sat_val = 16'h8000;
    end else begin
      sat_val = shifted[15:0];
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= C_ST_PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. Decisions use the registered fill from before this
  // cycle's push/pop, so a same-cycle push cannot rescue an empty FIFO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_PRIME: if (fill_q >= C_PRIME_LVL) state_d = C_ST_PLAY;
      C_ST_PLAY:  if (sample_tick_in && (fill_q == '0)) state_d = C_ST_PRIME;
      default:    state_d = C_ST_PRIME;
    endcase
  end

  // FSM: outputs. Every tick produces a sample; only a PLAY tick with data
  // pops, everything else replays silence.
  always_comb begin
    pop           = 1'b0;
    emit_zero     = 1'b1;
    underflow_set = 1'b0;
    if (sample_tick_in && (state_q == C_ST_PLAY)) begin
      if (fill_q != '0) begin
        pop       = 1'b1;
        emit_zero = 1'b0;
      end else begin
        underflow_set = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO bookkeeping, address check and sticky flags
  // --------------------------------------------------------------------------
  always_comb begin
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push_ok      = valid_in && ((fill_q != C_FULL) || pop);
    overflow_set = valid_in && !push_ok;
    // Index 0 always marks a fresh window and is never an error.
    addr_err_set = valid_in && (addr_in != '0) && (addr_in != exp_addr_q);

    fill_d = fill_q;
    case ({push_ok, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase

    wr_ptr_d   = push_ok  ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop      ? rd_ptr_q + PW'(1) : rd_ptr_q;
    exp_addr_d = valid_in ? addr_in + AW'(1)  : exp_addr_q;

    // Set has priority over clear.
    overflow_d  = overflow_set  | (overflow_q  & ~clear_flags_in);
    underflow_d = underflow_set | (underflow_q & ~clear_flags_in);
    addr_err_d  = addr_err_set  | (addr_err_q  & ~clear_flags_in);
  end

  // --------------------------------------------------------------------------
  // Output pipeline: stage 1 aligns with the RAM read, stage 2 registers the
  // sample, giving a fixed two-cycle tick-to-valid latency in both states.
  // --------------------------------------------------------------------------
  always_comb begin
    tick1_d  = sample_tick_in;
    zero1_d  = emit_zero;
    valid_d  = tick1_q;
    sample_d = sample_q;
    if (tick1_q) begin
      sample_d = zero1_q ? 16'h0000 : rd_data_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fill_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      exp_addr_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      addr_err_q  <= 1'b0;
      tick1_q     <= 1'b0;
      zero1_q     <= 1'b0;
      valid_q     <= 1'b0;
      sample_q    <= '0;
    end else begin
      fill_q      <= fill_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      exp_addr_q  <= exp_addr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      addr_err_q  <= addr_err_d;
      tick1_q     <= tick1_d;
      zero1_q     <= zero1_d;
      valid_q     <= valid_d;
      sample_q    <= sample_d;
    end
  end

  // RAM: when full, a simultaneous push and pop hit the same slot; the read
  // returns the old entry, which is the one being popped.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      ram_q[wr_ptr_q] <= sat_val;
    end
    if (pop) begin
      rd_data_q <= ram_q[rd_ptr_q];
    end
  end

  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign fill_out         = fill_q;
  assign playing_out      = (state_q == C_ST_PLAY);
  assign overflow_out     = overflow_q;
  assign underflow_out    = underflow_q;
  assign addr_err_out     = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_psola_output_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_psola_output_streamer
// Purpose  : Directed self-checking bench for psola_output_streamer.
// Revision : 1.0  initial release
// ============================================================================
module tb_psola_output_streamer;

  localparam int AW = 12;
  localparam int FW = 13;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [31:0]   val_in;
  logic [AW-1:0] addr_in;
  logic          valid_in;
  logic          sample_tick_in;
  logic          clear_flags_in;
  logic [15:0]   sample_out;
  logic          sample_valid_out;
  logic [FW-1:0] fill_out;
  logic          playing_out;
  logic          overflow_out;
  logic          underflow_out;
  logic          addr_err_out;

  int checks = 0;
  int errors = 0;

  psola_output_streamer dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .val_in           (val_in),
    .addr_in          (addr_in),
    .valid_in         (valid_in),
    .sample_tick_in   (sample_tick_in),
    .clear_flags_in   (clear_flags_in),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .fill_out         (fill_out),
    .playing_out      (playing_out),
    .overflow_out     (overflow_out),
    .underflow_out    (underflow_out),
    .addr_err_out     (addr_err_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in       = 1'b0;
    valid_in       = 1'b0;
    sample_tick_in = 1'b0;
    clear_flags_in = 1'b0;
    step();
    step();
    rst_n_in = 1'b1;
    step();
  endtask

  task automatic push(input logic [31:0] v, input logic [AW-1:0] a);
    valid_in = 1'b1;
    val_in   = v;
    addr_in  = a;
    step();
    valid_in = 1'b0;
  endtask

  // One isolated tick; returns valid one and two cycles later plus the sample.
  task automatic tick_get(output logic v_early, output logic v_on, output logic [15:0] s);
    sample_tick_in = 1'b1;
    step();
    sample_tick_in = 1'b0;
    v_early = sample_valid_out;
    step();
    v_on = sample_valid_out;
    s    = sample_out;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; valid_in = 1'b0; sample_tick_in = 1'b0; clear_flags_in = 1'b0;
    val_in = '0; addr_in = '0;
    #2;
    checks++;
    if (sample_out !== 16'd0 || sample_valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_sample: got %0h/%0b expected 0/0", sample_out, sample_valid_out);
    end
    checks++;
    if (fill_out !== '0 || playing_out !== 1'b0) begin
      errors++; $display("FAIL reset_fill_state: got fill %0d playing %0b expected 0/0", fill_out, playing_out);
    end
    checks++;
    if (overflow_out !== 1'b0 || underflow_out !== 1'b0 || addr_err_out !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got %0b%0b%0b expected 000", overflow_out, underflow_out, addr_err_out);
    end
    step(); step();
    rst_n_in = 1'b1;
    step();
    checks++;
    if (fill_out !== '0 || playing_out !== 1'b0) begin
      errors++; $display("FAIL reset_release: got fill %0d playing %0b expected 0/0", fill_out, playing_out);
    end
  endtask

  task automatic test_prime_tick();
    logic ve, vo;
    logic [15:0] s;
    tick_get(ve, vo, s);
    checks++;
    if (ve !== 1'b0 || vo !== 1'b1) begin
      errors++; $display("FAIL prime_tick_latency: got early %0b on %0b expected 0/1", ve, vo);
    end
    checks++;
    if (s !== 16'd0 || fill_out !== '0 || playing_out !== 1'b0) begin
      errors++; $display("FAIL prime_tick_value: got sample %0d fill %0d playing %0b expected 0/0/0", s, fill_out, playing_out);
    end
  endtask

  task automatic test_stream();
    int m;
    logic exp_v;
    for (int i = 0; i < 1200; i++) begin
      push(32'(i) << 8, AW'(i));
      if (i == 1022 || i == 1023 || i == 1024) begin
        checks++;
        if (fill_out !== FW'(i + 1) || playing_out !== (i >= 1024)) begin
          errors++; $display("FAIL stream_prime_%0d: got fill %0d playing %0b expected %0d/%0b",
                             i, fill_out, playing_out, i + 1, (i >= 1024));
        end
      end
    end
    checks++;
    if (fill_out !== FW'(1200) || playing_out !== 1'b1) begin
      errors++; $display("FAIL stream_filled: got fill %0d playing %0b expected 1200/1", fill_out, playing_out);
    end
    // Eight back-to-back ticks: samples 0..7 appear two cycles after each tick.
    sample_tick_in = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step();
      m = k + 1;
      sample_tick_in = (m < 8);
      exp_v = (m >= 2 && m <= 9);
      checks++;
      if (sample_valid_out !== exp_v || (exp_v && sample_out !== 16'(m - 2))) begin
        errors++; $display("FAIL b2b_cycle_%0d: got valid %0b sample %0d expected %0b/%0d",
                           m, sample_valid_out, sample_out, exp_v, m - 2);
      end
    end
    checks++;
    if (fill_out !== FW'(1192)) begin
      errors++; $display("FAIL b2b_fill: got %0d expected 1192", fill_out);
    end
  endtask

  task automatic test_reset_mid_burst();
    valid_in = 1'b1; val_in = 32'h0000_1000; addr_in = AW'(1200);
    step();
    #2;
    rst_n_in = 1'b0;
    #1;
    checks++;
    if (sample_out !== 16'd0 || fill_out !== '0 || playing_out !== 1'b0) begin
      errors++; $display("FAIL reset_async: got sample %0d fill %0d playing %0b expected 0/0/0",
                         sample_out, fill_out, playing_out);
    end
    valid_in = 1'b0;
    step(); step();
    rst_n_in = 1'b1;
    step();
    checks++;
    if (fill_out !== '0 || playing_out !== 1'b0) begin
      errors++; $display("FAIL reset_mid_release: got fill %0d playing %0b expected 0/0", fill_out, playing_out);
    end
  endtask

  task automatic test_sat_underflow();
    logic ve, vo;
    logic [15:0] s, exp_s;
    logic [31:0] v;
    for (int i = 0; i < 1024; i++) begin
      if (i == 0)      v = 32'h7FFF_FFFF;
      else if (i == 1) v = 32'h8000_0000;
      else if (i == 2) v = 32'hFFFF_FF00;
      else             v = 32'(i) << 8;
      push(v, AW'(i));
    end
    step(); step();
    checks++;
    if (fill_out !== FW'(1024) || playing_out !== 1'b1) begin
      errors++; $display("FAIL uf_primed: got fill %0d playing %0b expected 1024/1", fill_out, playing_out);
    end
    for (int k = 0; k < 1025; k++) begin
      if (k == 1024) begin
        checks++;
        if (underflow_out !== 1'b0) begin
          errors++; $display("FAIL uf_before: got %0b expected 0", underflow_out);
        end
      end
      tick_get(ve, vo, s);
      if (k == 0)         exp_s = 16'h7FFF;
      else if (k == 1)    exp_s = 16'h8000;
      else if (k == 2)    exp_s = 16'hFFFF;
      else if (k == 1024) exp_s = 16'h0000;
      else                exp_s = 16'(k);
      checks++;
      if (ve !== 1'b0 || vo !== 1'b1 || s !== exp_s) begin
        errors++; $display("FAIL play_sample_%0d: got early %0b valid %0b sample %0h expected 0/1/%0h",
                           k, ve, vo, s, exp_s);
      end
    end
    checks++;
    if (underflow_out !== 1'b1 || playing_out !== 1'b0 || fill_out !== '0) begin
      errors++; $display("FAIL uf_after: got underflow %0b playing %0b fill %0d expected 1/0/0",
                         underflow_out, playing_out, fill_out);
    end
  endtask

  task automatic test_full();
    logic ve, vo;
    logic [15:0] s;
    do_reset();
    for (int i = 0; i < 4096; i++) begin
      push(32'(i + 5) << 8, AW'(i % 2000));
    end
    checks++;
    if (fill_out !== FW'(4096) || overflow_out !== 1'b0) begin
      errors++; $display("FAIL full_4096: got fill %0d overflow %0b expected 4096/0", fill_out, overflow_out);
    end
    push(32'(7) << 8, AW'(96));
    checks++;
    if (fill_out !== FW'(4096) || overflow_out !== 1'b1) begin
      errors++; $display("FAIL full_overflow: got fill %0d overflow %0b expected 4096/1", fill_out, overflow_out);
    end
    clear_flags_in = 1'b1;
    step();
    clear_flags_in = 1'b0;
    checks++;
    if (overflow_out !== 1'b0) begin
      errors++; $display("FAIL full_clear: got overflow %0b expected 0", overflow_out);
    end
    // Push and pop together while full: accepted, oldest entry comes out.
    valid_in = 1'b1; val_in = 32'(9999) << 8; addr_in = AW'(97);
    sample_tick_in = 1'b1;
    step();
    valid_in = 1'b0; sample_tick_in = 1'b0;
    step();
    checks++;
    if (sample_valid_out !== 1'b1 || sample_out !== 16'd5) begin
      errors++; $display("FAIL full_pushpop_sample: got valid %0b sample %0d expected 1/5", sample_valid_out, sample_out);
    end
    checks++;
    if (fill_out !== FW'(4096) || overflow_out !== 1'b0 || addr_err_out !== 1'b0) begin
      errors++; $display("FAIL full_pushpop_state: got fill %0d overflow %0b adderr %0b expected 4096/0/0",
                         fill_out, overflow_out, addr_err_out);
    end
    tick_get(ve, vo, s);
    checks++;
    if (vo !== 1'b1 || s !== 16'd6 || fill_out !== FW'(4095)) begin
      errors++; $display("FAIL full_next_pop: got valid %0b sample %0d fill %0d expected 1/6/4095", vo, s, fill_out);
    end
  endtask

  task automatic test_addr();
    do_reset();
    push(32'h0, AW'(0));
    push(32'h0, AW'(1));
    push(32'h0, AW'(2));
    checks++;
    if (addr_err_out !== 1'b0) begin
      errors++; $display("FAIL addr_seq: got %0b expected 0", addr_err_out);
    end
    push(32'h0, AW'(4));
    checks++;
    if (addr_err_out !== 1'b1) begin
      errors++; $display("FAIL addr_skip: got %0b expected 1", addr_err_out);
    end
    clear_flags_in = 1'b1;
    step();
    clear_flags_in = 1'b0;
    checks++;
    if (addr_err_out !== 1'b0) begin
      errors++; $display("FAIL addr_clear: got %0b expected 0", addr_err_out);
    end
    push(32'h0, AW'(0));
    push(32'h0, AW'(1));
    push(32'h0, AW'(2));
    checks++;
    if (addr_err_out !== 1'b0) begin
      errors++; $display("FAIL addr_restart: got %0b expected 0", addr_err_out);
    end
    // Error event and clear in the same cycle: the event wins.
    clear_flags_in = 1'b1;
    push(32'h0, AW'(9));
    clear_flags_in = 1'b0;
    checks++;
    if (addr_err_out !== 1'b1) begin
      errors++; $display("FAIL addr_set_wins: got %0b expected 1", addr_err_out);
    end
    checks++;
    if (fill_out !== FW'(8)) begin
      errors++; $display("FAIL addr_fill: got %0d expected 8", fill_out);
    end
  endtask

  initial begin
    test_reset();
    test_prime_tick();
    test_stream();
    test_reset_mid_burst();
    test_sat_underflow();
    test_full();
    test_addr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
